// File: rtl/uart_pkg.sv
// Shared UART constants and the arbiter state encoding.
// Baud divisors are used by the TX/RX byte engines that sit beside the arbiter.
package uart_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState_t;

    localparam int UART_DATA_W     = 8;
    localparam int CLK_HZ          = 27_000_000;
    localparam int BAUD_DIV_115200 = 234;
    localparam int BAUD_DIV_9600   = 2812;

    // Truncating divide, which is how the fixed divisors above were derived.
    function automatic int baudDiv(input int baud);
        return CLK_HZ / baud;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit strictly after
// `last`, wrapping, so the most recent winner has the lowest priority.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest hit is written last.
    always_comb begin
        any  = |req;
        idx  = '0;
        cand = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IDX_W'((int'(last) + off) % NUM_REQ);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX byte engine among NUM_REQ requesters.
// A grant is held for a packet: until req_last, MAX_BURST bytes, or idle timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int MAX_BURST    = 16,
    parameter  int IDLE_TIMEOUT = 255,
    localparam int IDX_W        = $clog2(NUM_REQ),
    localparam int BURST_W      = $clog2(MAX_BURST + 1),
    localparam int IDLE_W       = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_valid,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic [IDX_W-1:0]               grant_id,
    output logic                           busy
);

    arbState_t state, stateNext;

    logic [IDX_W-1:0]                        lastGrant;
    logic [BURST_W-1:0]                      burstCnt;
    logic [IDLE_W-1:0]                       idleCnt;
    logic [NUM_REQ-1:0][UART_DATA_W-1:0]     reqBytes;

    logic             pickAny;
    logic [IDX_W-1:0] pickIdx;
    logic             gValid;
    logic             gLast;
    logic             xfer;
    logic             burstDone;
    logic             timeoutHit;
    logic             endGrant;

    assign reqBytes = req_data;

    rr_pick #(.NUM_REQ(NUM_REQ)) uPick (
        .req  (req_valid),
        .last (lastGrant),
        .any  (pickAny),
        .idx  (pickIdx)
    );

    assign gValid     = req_valid[grant_id];
    assign gLast      = req_last[grant_id];
    assign xfer       = (state == GRANT) && gValid && tx_ready;
    assign burstDone  = (int'(burstCnt) + 1 == MAX_BURST);
    // Independent of this cycle's req_valid: a request rising on the expiry cycle still loses the grant.
    assign timeoutHit = (int'(idleCnt) + 1 == IDLE_TIMEOUT);
    assign endGrant   = (xfer && (gLast || burstDone)) || timeoutHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (pickAny)  stateNext = GRANT;
            GRANT: if (endGrant) stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == GRANT);
        tx_valid  = 1'b0;
        tx_data   = '0;
        req_ready = '0;
        if (state == GRANT) begin
            tx_valid            = gValid;
            tx_data             = reqBytes[grant_id];
            req_ready[grant_id] = tx_ready;
        end
    end

    // Grant bookkeeping; counters are cleared on every new grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id  <= '0;
            lastGrant <= IDX_W'(NUM_REQ - 1);
            burstCnt  <= '0;
            idleCnt   <= '0;
        end else if (state == IDLE) begin
            if (pickAny) begin
                grant_id  <= pickIdx;
                lastGrant <= pickIdx;
                burstCnt  <= '0;
                idleCnt   <= '0;
            end
        end else begin
            if (xfer) begin
                if (burstCnt != BURST_W'(MAX_BURST)) burstCnt <= burstCnt + 1'b1;
                idleCnt <= '0;
            end else if (!gValid && idleCnt != IDLE_W'(IDLE_TIMEOUT)) begin
                idleCnt <= idleCnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a packet-level
// reference model of the round-robin grant rules.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N  = 4;
    localparam int MB = 4;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready, busy;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Per-requester packet queues: {last, data}
    logic [8:0] pq [N][256];
    logic [7:0] hd [N];
    logic [7:0] tl [N];
    logic [N-1:0] en;
    logic txr;

    // Reference model state
    bit mBusy;
    int mGrant, mLast, mIdle, mBytes;

    int  glog[$];
    int  xlog[$];
    int  nRdy;
    bit  prevBusy;

    task automatic push(input int r, input logic [7:0] d, input logic last);
        pq[r][tl[r]] = {last, d};
        tl[r] = tl[r] + 8'd1;
    endtask

    task automatic cyc();
        logic [N-1:0]   v, l, eRdy;
        logic [8*N-1:0] d;
        bit done, xf;
        int g, pick;
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            v[r]       = (hd[r] != tl[r]) && en[r];
            d[8*r +: 8] = (hd[r] != tl[r]) ? pq[r][hd[r]][7:0] : 8'($urandom);
            l[r]       = (hd[r] != tl[r]) ? pq[r][hd[r]][8] : 1'($urandom);
        end
        req_valid = v; req_data = d; req_last = l; tx_ready = txr;
        #1;
        g = mGrant;
        eRdy = '0;
        if (mBusy && txr) eRdy[g] = 1'b1;
        chk("busy", busy, mBusy);
        chk("grant_id", grant_id, g);
        chk("tx_valid", tx_valid, mBusy && v[g]);
        chk("tx_data", tx_data, mBusy ? d[8*g +: 8] : 8'h00);
        chk("req_ready", req_ready, eRdy);
        if (busy && !prevBusy) glog.push_back(int'(grant_id));
        prevBusy = busy;
        if (tx_valid && tx_ready) xlog.push_back(int'(tx_data));
        if (|req_ready) nRdy++;
        if (!mBusy) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && v[(mLast + k) % N]) pick = (mLast + k) % N;
            if (pick >= 0) begin
                mBusy = 1; mGrant = pick; mLast = pick; mBytes = 0; mIdle = 0;
            end
        end else begin
            done = (mIdle + 1 == TO);
            xf   = v[g] && txr;
            if (xf) begin
                mBytes++;
                mIdle = 0;
                hd[g] = hd[g] + 8'd1;
                if (l[g] || mBytes == MB) done = 1;
            end else if (!v[g] && mIdle < TO) begin
                mIdle++;
            end
            if (done) mBusy = 0;
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_grant_id", grant_id, 0);
        mBusy = 0; mGrant = 0; mLast = N - 1; mIdle = 0; mBytes = 0;
        prevBusy = 0; nRdy = 0;
        glog.delete(); xlog.delete();
        for (int r = 0; r < N; r++) hd[r] = tl[r];
        en = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
        tx_ready = 1'b0; txr = 1'b0; en = '0;
        for (int r = 0; r < N; r++) begin hd[r] = 8'd0; tl[r] = 8'd0; end

        // Round-robin with 1-byte packets from everyone
        doReset();
        en = '1; txr = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int r = 0; r < N; r++) if (hd[r] == tl[r]) push(r, 8'(8'h10 + r), 1'b1);
            cyc();
        end
        chk("rr_count", glog.size(), 5);
        chk("rr_g0", glog[0], 0); chk("rr_g1", glog[1], 1); chk("rr_g2", glog[2], 2);
        chk("rr_g3", glog[3], 3); chk("rr_g4", glog[4], 0);

        // Single requester packet
        doReset();
        en = 4'b0100; txr = 1'b1;
        push(2, 8'h4D, 1'b0); push(2, 8'h34, 1'b0); push(2, 8'h6E, 1'b1);
        for (int c = 0; c < 6; c++) cyc();
        chk("single_count", xlog.size(), 3);
        chk("single_b0", xlog[0], 8'h4D); chk("single_b1", xlog[1], 8'h34);
        chk("single_b2", xlog[2], 8'h6E); chk("single_gid", glog[0], 2);

        // Burst limit: req1 streams without last, req3 competes
        doReset();
        en = 4'b1010; txr = 1'b1;
        for (int i = 0; i < 10; i++) push(1, 8'(8'h60 + i), 1'b0);
        for (int i = 0; i < 3; i++) push(3, 8'(8'hC0 + i), 1'b1);
        for (int c = 0; c < 40; c++) cyc();
        chk("burst_count", glog.size(), 6);
        chk("burst_g0", glog[0], 1); chk("burst_g1", glog[1], 3); chk("burst_g2", glog[2], 1);
        chk("burst_g3", glog[3], 3); chk("burst_g4", glog[4], 1);

        // Idle timeout: req0 goes quiet, req1 waits
        doReset();
        en = 4'b0011; txr = 1'b1;
        push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(1, 8'h11, 1'b1);
        for (int c = 0; c < 16; c++) cyc();
        chk("tmo_count", glog.size(), 2);
        chk("tmo_g1", glog[1], 1);

        // Backpressure: tx_ready 1 on, 3 off
        doReset();
        en = 4'b0100;
        for (int i = 0; i < 5; i++) push(2, 8'(8'hA0 + i), 1'(i == 4));
        for (int c = 0; c < 30; c++) begin
            txr = (c % 4 == 0);
            cyc();
        end
        chk("bp_count", xlog.size(), 5);
        chk("bp_rdy_pulses", nRdy, 5);
        for (int i = 0; i < 5; i++) chk("bp_byte", xlog[i], 8'hA0 + i);

        // Reset in the middle of req3's packet
        doReset();
        en = 4'b1000; txr = 1'b1;
        for (int i = 0; i < 4; i++) push(3, 8'(8'h30 + i), 1'(i == 3));
        cyc(); cyc();
        doReset();
        en = 4'b1001; txr = 1'b1;
        push(0, 8'h55, 1'b1); push(3, 8'h33, 1'b1);
        for (int c = 0; c < 6; c++) cyc();
        chk("rstmid_first", glog[0], 0);
        chk("rstmid_second", glog[1], 3);

        // Randomized traffic
        doReset();
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < N; r++) begin
                if (hd[r] == tl[r] && $urandom_range(7) == 0) begin
                    int len;
                    bit withLast;
                    len = $urandom_range(10, 1);
                    withLast = ($urandom_range(3) != 0);
                    for (int i = 0; i < len; i++)
                        push(r, 8'($urandom), 1'(withLast && i == len - 1));
                end
                en[r] = ($urandom_range(9) < 8);
            end
            txr = ($urandom_range(2) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter among `NUM_REQ` byte-stream requesters, such as the button-triggered banner sender, RX echo and status reporter. Round-robin grants are locked for a whole packet, which ends on `req_last`, after `MAX_BURST` bytes, or after an idle timeout. The block sits between the requesters and the UART TX byte engine, which exposes a valid/ready byte port.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `MAX_BURST`, 16, max bytes per grant before forced re-arbitration (≥1)
- `IDLE_TIMEOUT`, 255, cycles without `req_valid` from the granted requester before the grant is released (≥1)
- `clk` in 1: system clock (27 MHz)
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in NUM_REQ: byte available, one bit per requester
- `req_data` in 8*NUM_REQ: requester i byte at `[8*i+7:8*i]`
- `req_last` in NUM_REQ: byte is the last of its packet
- `req_ready` out NUM_REQ: byte accepted this cycle (one-hot or zero)
- `tx_valid` out 1: byte offered to the UART TX engine
- `tx_data` out 8: byte to transmit
- `tx_ready` in 1: TX engine accepts byte (idle, not mid-frame)
- `grant_id` out clog2(NUM_REQ): current or last granted requester
- `busy` out 1: a grant is held

## Operation
- State machine states: `IDLE`, `GRANT`.
- Reset value of all outputs is 0. Internal `last_grant` resets to NUM_REQ-1, so requester 0 wins first. Counters reset to 0.
- **IDLE:**
  - If any `req_valid` is set, pick the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - Register it into `grant_id` and `last_grant`, clear `burst_cnt` and `idle_cnt`, then go to `GRANT`.
  - With no `req_valid`, stay in `IDLE`.
- **GRANT (g = `grant_id`):**
  - `tx_valid` = `req_valid[g]`, `tx_data` = `req_data[g]`, `req_ready[g]` = `tx_ready`. All other `req_ready` bits are 0. These are combinational in GRANT and 0 in IDLE.
  - A transfer occurs when `tx_valid && tx_ready`. Each transfer increments `burst_cnt` and clears `idle_cnt`.
  - A cycle with `req_valid[g]`=0 increments `idle_cnt`, saturating.
  - Return to `IDLE` after a transfer with `req_last[g]`=1, or after a transfer where `burst_cnt`+1 == MAX_BURST.
  - Also return to `IDLE` when `idle_cnt`+1 == IDLE_TIMEOUT.
  - `busy` = (state == `GRANT`).
- Non-granted requesters are ignored. Their `req_valid`/`req_data` may change freely.
- The requester holds `req_data`/`req_last` stable while `req_valid`=1 and not accepted.
- `burst_cnt` is clog2(MAX_BURST+1) bits wide. `idle_cnt` is clog2(IDLE_TIMEOUT+1) bits wide. Neither wraps.

## Timing
- **Grant latency:** a request seen in IDLE at edge t yields `busy`=1 and `tx_valid` after edge t+1, i.e. one cycle.
- **Re-arbitration gap:** exactly one IDLE cycle between consecutive grants, even if the same requester is the only one valid.
- **Simultaneous last + burst limit:** a single release, no double-counting.
- **Release on `req_last`:** `req_ready` of the released requester drops in the cycle after the final transfer.
- **Timeout with `req_valid[g]` rising in the same cycle:** the timeout wins. No transfer is lost because `req_ready` is only asserted with `tx_ready` in GRANT.
- **Reset asserted mid-packet:** immediately forces IDLE, outputs 0, `last_grant`=NUM_REQ-1. A partially sent packet is abandoned; requesters must restart it.
- **Throughput:** back-to-back transfers are limited only by `tx_ready` (one byte per UART frame).

## Structure
- Package `uart_pkg`:
  - state enum `{IDLE, GRANT}`
  - `UART_DATA_W`=8
  - `CLK_HZ`=27_000_000
  - baud divisor constants (234 for 115200, 2812 for 9600), shared with the TX/RX engines
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs `req[NUM_REQ]`, `last[clog2]`. Outputs `any`, `idx`. Instantiated once.
- Top: `uart_tx_arbiter` FSM, counters and data/ready muxing, ~150–200 lines.

## Test plan
- **Single requester:** requester 2 sends 3 bytes 0x4D,0x34,0x6E, last on the third, `tx_ready`=1 -> `tx_data` sequence 0x4D,0x34,0x6E; `grant_id`=2; `busy` high 3 cycles then low.
- **Round-robin:** all 4 requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0; one idle cycle between each.
- **Burst limit:** MAX_BURST=4, requester 1 streams 10 bytes with `req_last` never set, requester 3 also valid -> grants 1(4 bytes), 3, 1(4), 3, 1(2).
- **Idle timeout:** IDLE_TIMEOUT=8, requester 0 granted, then drops `req_valid` -> `busy` falls after 8 cycles; waiting requester 1 is granted next.
- **Backpressure:** `tx_ready` toggles 1 cycle on, 3 off during a 5-byte packet -> exactly 5 transfers, data unchanged while stalled, no extra `req_ready` pulses.
- **Reset mid-packet:** `rst_n` pulsed low during the 2nd byte of requester 3's packet -> all outputs 0 within the reset; after release, requester 0 wins over 3 when both are valid.
